bsg_skid_buffer: RTL and testbench
==================================

Name: bsg_skid_buffer

Overview:
- Two-entry valid/ready skid buffer on a `width_p` data path.
- Sits directly upstream of a plain `bsg_dff` data register stage.
- Registers both the data and the backpressure path, so `ready_o` has no combinational dependence on `yumi_i`.
- Sustains one transfer per cycle; stages can be chained for timing closure.

Parameters:
- width_p, 64, data width in bits; legal range >= 1.

Ports:
- clk_i  input  1  single clock; all state updates on posedge.
- reset_i  input  1  asynchronous, active-high reset.
- v_i  input  1  upstream data valid.
- data_i  input  width_p  upstream data.
- ready_o  output  1  buffer can accept; driven from state registers only.
- v_o  output  1  downstream data valid.
- data_o  output  width_p  head data; driven from the main register.
- yumi_i  input  1  downstream consumes head this cycle; legal only when v_o=1.

Behaviour:
- Interface: one clock `clk_i`; reset `reset_i` is asynchronous and active-high.
- Definitions:
  - enq = v_i & ready_o.
  - deq = yumi_i & v_o.
  - v_i while ready_o=0 is ignored; no data capture.
- Storage:
  - main_r: head entry, drives data_o.
  - skid_r: second entry.
  - state_r encodes occupancy, one of EMPTY, ONE, FULL.
- Outputs:
  - v_o = (state_r != EMPTY).
  - ready_o = (state_r != FULL).
  - Both are pure functions of state_r.
- Transitions:
  - EMPTY: enq -> ONE, main_r<=data_i. Otherwise hold.
  - ONE, enq & !deq -> FULL, skid_r<=data_i.
  - ONE, !enq & deq -> EMPTY; main_r holds its stale value.
  - ONE, enq & deq -> ONE, main_r<=data_i (simultaneous pass-through).
  - ONE, neither -> hold.
  - FULL, deq -> ONE, main_r<=skid_r. enq cannot occur (ready_o=0).
  - FULL, !deq -> hold; data_o stable.
- Latency and throughput:
  - One cycle from enq to v_o when empty.
  - Steady-state throughput is 1 word/cycle with yumi_i held high.
- Ordering: strict FIFO; no loss, duplication or reordering.
- Reset:
  - Asserting reset_i forces state_r=EMPTY, main_r=0, skid_r=0 immediately, independent of clk_i.
  - During reset: v_o=0, ready_o=1, data_o=0.
  - Reset mid-operation discards all buffered data.
  - First enq accepted on the first posedge after reset_i deasserts.
- Protocol errors:
  - yumi_i=1 with v_o=0 is ignored (deq=0).
  - Simulation assertion fires, guarded by ~reset_i.
- Data hold: data_o does not change while v_o=1 & yumi_i=0.
- Unused encodings: an illegal state_r value returns to EMPTY on the next clock.

Decomposition:
- Shared package bsg_skid_buffer_pkg:
  - 2-bit enum bsg_skid_state_e {e_empty, e_one, e_full}.
  - Localparam for state width.
- One natural sub-module: bsg_dff_en_ar.
  - Parameter width_p.
  - Enable-gated register with async active-high reset to 0.
  - Instantiated twice, for main_r and skid_r.
- State register and next-state logic stay in the top module.

Test Plan:
- Reset then idle: assert reset_i mid-cycle -> v_o=0, ready_o=1, data_o=0 immediately, without waiting for a clock edge; hold 3 cycles -> no change.
- Single transfer: v_i=1, data_i=64'hDEAD_BEEF_0000_0001 for one cycle, yumi_i=1 when v_o=1 -> v_o=1 next cycle with that data; EMPTY after consume.
- Fill and stall: send 64'h1, 64'h2 back-to-back with yumi_i=0 -> after 2 cycles ready_o=0, data_o=64'h1; third word 64'h3 with v_i=1 is ignored; yumi_i=1 -> data_o=64'h2 next cycle, ready_o=1.
- Streaming: 100 incrementing words with v_i=1, yumi_i=1 continuously -> one word per cycle after 1-cycle latency, exact order, ready_o never drops.
- Random backpressure: random v_i/yumi_i, 10k cycles -> scoreboard matches with no loss; data_o stable whenever v_o=1 & yumi_i=0.
- Reset while FULL: fill with 64'hA, 64'hB, assert reset_i -> v_o=0, ready_o=1 asynchronously; after release, new word 64'hC emerges first.

Source files
------------

// File: rtl/bsg_skid_buffer_pkg.sv
// Shared types for the two-entry skid buffer: occupancy encoding and its width.
package bsg_skid_buffer_pkg;

    localparam int skid_state_width_lp = 2;

    // 2'b11 is unused; the top folds it back to e_empty on the next clock.
    typedef enum logic [skid_state_width_lp-1:0] {
        e_empty = 2'b00,
        e_one   = 2'b01,
        e_full  = 2'b10
    } bsg_skid_state_e;

endpackage

// File: rtl/bsg_dff_en_ar.sv
// Enable-gated data register with asynchronous active-high clear to zero.
module bsg_dff_en_ar
    import bsg_skid_buffer_pkg::*;
#(
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_r;

    // Load on enable; reset clears immediately, independent of the clock.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            data_r <= '0;
        else if (en_i)
            data_r <= data_i;
    end

    assign data_o = data_r;

endmodule

// File: rtl/bsg_skid_buffer.sv
// Two-entry valid/ready skid buffer. main_r is the head and drives data_o;
// skid_r catches the word accepted while the head is stalled. ready_o and v_o
// come straight from the occupancy register, so ready_o never depends on yumi_i.
module bsg_skid_buffer
    import bsg_skid_buffer_pkg::*;
#(
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    bsg_skid_state_e    state_r, state_n;
    logic               enq, deq;
    logic               main_en, skid_en, main_from_skid;
    logic [width_p-1:0] main_d, skid_q;

    assign v_o     = (state_r != e_empty);
    assign ready_o = (state_r != e_full);

    // A yumi with nothing valid, or a valid while full, is simply dropped here.
    assign enq = v_i & ready_o;
    assign deq = yumi_i & v_o;

    // Occupancy register; reset discards anything buffered.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            state_r <= e_empty;
        else
            state_r <= state_n;
    end

    // Next occupancy and which storage entries load this cycle.
    always_comb begin
        state_n        = state_r;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_r)
            e_empty: begin
                if (enq) begin
                    state_n = e_one;
                    main_en = 1'b1;
                end
            end
            e_one: begin
                case ({enq, deq})
                    2'b10: begin
                        state_n = e_full;
                        skid_en = 1'b1;
                    end
                    2'b01: begin
                        // Head goes invalid; main_r keeps its stale contents.
                        state_n = e_empty;
                    end
                    2'b11: begin
                        // Simultaneous consume and refill: new word becomes head.
                        main_en = 1'b1;
                    end
                    default: ;
                endcase
            end
            e_full: begin
                // enq is impossible here since ready_o is low.
                if (deq) begin
                    state_n        = e_one;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_n = e_empty;
        endcase
    end

    assign main_d = main_from_skid ? skid_q : data_i;

    bsg_dff_en_ar #(.width_p(width_p)) main_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (main_en),
        .data_i  (main_d),
        .data_o  (data_o)
    );

    bsg_dff_en_ar #(.width_p(width_p)) skid_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (skid_en),
        .data_i  (data_i),
        .data_o  (skid_q)
    );

    // Downstream must not consume an empty buffer.
    assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));

endmodule

// File: tb/tb_bsg_skid_buffer.sv
// Scoreboard bench for bsg_skid_buffer: a reference queue models occupancy and
// ordering; outputs are checked once per cycle at the falling edge.
module tb_bsg_skid_buffer;

    localparam int W = 64;

    logic         clk_i;
    logic         reset_i;
    logic         v_i;
    logic [W-1:0] data_i;
    logic         ready_o;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         yumi_i;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] q[$];

    bsg_skid_buffer #(.width_p(W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at the falling edge, check outputs against the model,
    // update the model with the handshakes the buffer should perform.
    task automatic step(input logic v, input logic [W-1:0] d, input logic y);
        logic yy, enq, deq;
        yy = y && (q.size() > 0);
        v_i = v; data_i = d; yumi_i = yy;
        #1;
        chk("v_o", {63'd0, v_o}, {63'd0, q.size() > 0});
        chk("ready_o", {63'd0, ready_o}, {63'd0, q.size() < 2});
        if (q.size() > 0) chk("data_o", data_o, q[0]);
        enq = v && (q.size() < 2);
        deq = yy;
        if (deq) void'(q.pop_front());
        if (enq) q.push_back(d);
        @(negedge clk_i);
    endtask

    // Mid-cycle asynchronous reset; effect must be visible before any clock edge.
    task automatic async_reset(input int hold_cycles);
        v_i = 1'b0; yumi_i = 1'b0; data_i = '0;
        #2 reset_i = 1'b1;
        #1;
        chk("rst_v_o", {63'd0, v_o}, 64'd0);
        chk("rst_ready_o", {63'd0, ready_o}, 64'd1);
        chk("rst_data_o", data_o, 64'd0);
        q.delete();
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk_i);
            chk("rst_hold_v_o", {63'd0, v_o}, 64'd0);
            chk("rst_hold_ready_o", {63'd0, ready_o}, 64'd1);
            chk("rst_hold_data_o", data_o, 64'd0);
        end
        reset_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() > 0; i++) step(1'b0, '0, 1'b1);
        chk("drained", 64'(q.size()), 64'd0);
        step(1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ctr;
        v_i = 1'b0; data_i = '0; yumi_i = 1'b0; reset_i = 1'b0;

        // Reset then idle
        @(negedge clk_i);
        async_reset(3);
        step(1'b0, '0, 1'b0);

        // Single transfer
        step(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Fill and stall: third word offered while full must be ignored
        step(1'b1, 64'h1, 1'b0);
        step(1'b1, 64'h2, 1'b0);
        chk("fill_ready_low", {63'd0, ready_o}, 64'd0);
        chk("fill_head", data_o, 64'h1);
        step(1'b1, 64'h3, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("stall_next_head", data_o, 64'h2);
        chk("stall_ready_back", {63'd0, ready_o}, 64'd1);
        drain();

        // Streaming: 100 words with yumi held high
        for (int i = 0; i < 100; i++) step(1'b1, 64'(i + 100), 1'b1);
        drain();

        // Random traffic with backpressure
        ctr = 64'h5000;
        for (int i = 0; i < 10000; i++) begin
            logic v;
            v = ($urandom_range(0, 99) < 60);
            step(v, ctr, ($urandom_range(0, 99) < 55));
            if (v) ctr = ctr + 64'h1;
        end
        drain();

        // Reset while full
        step(1'b1, 64'hA, 1'b0);
        step(1'b1, 64'hB, 1'b0);
        chk("full_before_reset", {63'd0, ready_o}, 64'd0);
        async_reset(1);
        @(negedge clk_i);
        step(1'b1, 64'hC, 1'b0);
        chk("post_reset_head", data_o, 64'hC);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
